// File: rtl/ctrl_pipe_pkg.sv
// Control-word layout and shared constants for the E/M/W control pipeline.
package ctrl_pipe_pkg;

    // Control word field positions (13-bit decoded word from Decode).
    localparam int unsigned MEMTOREG     = 12;
    localparam int unsigned MEMWRITE     = 11;
    localparam int unsigned ALUSRC       = 10;
    localparam int unsigned REGDST       = 9;
    localparam int unsigned REGWRITE     = 8;
    localparam int unsigned ALUCTRL_HI   = 2;
    localparam int unsigned ALUCTRL_LO   = 0;

    localparam int unsigned CW_DEFAULT   = 13;
    localparam int unsigned RW_DEFAULT   = 5;

    // A bubble carries no control effects: every control bit low.
    localparam logic [CW_DEFAULT-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_stage.sv
// One pipeline stage register: asynchronous clear, clear-to-bubble, hold, else load.
module ctrl_stage #(
    parameter int unsigned W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Next state: clear beats hold, hold beats load; an all-zero entry is a bubble.
    always_comb begin
        data_d = d_i;
        if (clr_i) begin
            data_d = '0;
        end else if (hold_i) begin
            data_d = data_q;
        end
    end

    // Stage register with asynchronous clear to bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ctrl_pipeline.sv
// Control-word pipeline from Decode through NSTAGE stages with stall/flush
// and load-use detection that stalls Decode.
module ctrl_pipeline
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned CW           = CW_DEFAULT,
    parameter int unsigned NSTAGE       = 3,
    parameter int unsigned RW           = RW_DEFAULT,
    parameter int unsigned MEMTOREG_BIT = MEMTOREG,
    parameter int unsigned REGWRITE_BIT = REGWRITE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CW-1:0]        ctrl_d,
    input  logic                 valid_d,
    input  logic [RW-1:0]        dst_d,
    input  logic [RW-1:0]        rs_d,
    input  logic [RW-1:0]        rt_d,
    input  logic                 use_rs_d,
    input  logic                 use_rt_d,
    input  logic [NSTAGE-1:0]    stall_i,
    input  logic [NSTAGE-1:0]    flush_i,
    output logic [NSTAGE*CW-1:0] ctrl_q,
    output logic [NSTAGE-1:0]    valid_q,
    output logic [NSTAGE*RW-1:0] dst_q,
    output logic                 stall_d,
    output logic                 loaduse
);

    // Stage entry layout: {valid, dst, ctrl}.
    localparam int unsigned SW = CW + RW + 1;

    logic [NSTAGE-1:0] hold;
    logic [NSTAGE-1:0] stage_clr;
    logic [SW-1:0]     stage_in [NSTAGE];
    logic [SW-1:0]     stage_q  [NSTAGE];

    logic              s0_valid;
    logic [CW-1:0]     s0_ctrl;
    logic [RW-1:0]     s0_dst;

    assign s0_valid = stage_q[0][SW-1];
    assign s0_dst   = stage_q[0][CW +: RW];
    assign s0_ctrl  = stage_q[0][CW-1:0];

    // Hold chain: a stall at any stage freezes that stage and every earlier one.
    always_comb begin
        hold = '0;
        hold[NSTAGE-1] = stall_i[NSTAGE-1];
        for (int k = int'(NSTAGE) - 2; k >= 0; k--) begin
            hold[k] = stall_i[k] | hold[k+1];
        end
    end

    // Load-use: a load in E writing a nonzero register that Decode reads.
    always_comb begin
        loaduse = s0_valid & s0_ctrl[MEMTOREG_BIT] & s0_ctrl[REGWRITE_BIT]
                & (s0_dst != '0) & valid_d
                & ((use_rs_d & (rs_d == s0_dst)) | (use_rt_d & (rt_d == s0_dst)));
        stall_d = hold[0] | loaduse;
    end

    for (genvar g = 0; g < int'(NSTAGE); g++) begin : g_stage
        if (g == 0) begin : g_first
            assign stage_in[g]  = {valid_d, dst_d, ctrl_d};
            // Loaduse inserts a bubble only when E is not frozen.
            assign stage_clr[g] = flush_i[g] | (~hold[g] & loaduse);
        end else begin : g_rest
            assign stage_in[g]  = stage_q[g-1];
            // Upstream frozen while this stage drains: take a bubble.
            assign stage_clr[g] = flush_i[g] | (~hold[g] & hold[g-1]);
        end

        ctrl_stage #(
            .W (SW)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .hold_i (hold[g]),
            .clr_i  (stage_clr[g]),
            .d_i    (stage_in[g]),
            .q_o    (stage_q[g])
        );

        assign ctrl_q[g*CW +: CW] = stage_q[g][CW-1:0];
        assign dst_q[g*RW +: RW]  = stage_q[g][CW +: RW];
        assign valid_q[g]         = stage_q[g][SW-1];
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: directed plan steps, then random traffic,
// compared against a stage-array reference model.
module tb_ctrl_pipeline;

    localparam int CW = 13;
    localparam int NS = 3;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [CW-1:0]   ctrl_d;
    logic            valid_d;
    logic [RW-1:0]   dst_d, rs_d, rt_d;
    logic            use_rs_d, use_rt_d;
    logic [NS-1:0]   stall_i, flush_i;
    logic [NS*CW-1:0] ctrl_q;
    logic [NS-1:0]   valid_q;
    logic [NS*RW-1:0] dst_q;
    logic            stall_d, loaduse;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: contents of each stage.
    logic          m_v [NS];
    logic [CW-1:0] m_c [NS];
    logic [RW-1:0] m_d [NS];

    ctrl_pipeline dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl_d   (ctrl_d),
        .valid_d  (valid_d),
        .dst_d    (dst_d),
        .rs_d     (rs_d),
        .rt_d     (rt_d),
        .use_rs_d (use_rs_d),
        .use_rt_d (use_rt_d),
        .stall_i  (stall_i),
        .flush_i  (flush_i),
        .ctrl_q   (ctrl_q),
        .valid_q  (valid_q),
        .dst_q    (dst_q),
        .stall_d  (stall_d),
        .loaduse  (loaduse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_loaduse();
        logic is_load;
        is_load = m_v[0] && m_c[0][12] && m_c[0][8] && (m_d[0] != 0);
        return is_load && valid_d &&
               ((use_rs_d && rs_d == m_d[0]) || (use_rt_d && rt_d == m_d[0]));
    endfunction

    // A stage is held if it or anything downstream requests a stall.
    function automatic logic model_hold(input int k);
        return (stall_i >> k) != 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NS; k++) begin
            m_v[k] = 1'b0;
            m_c[k] = '0;
            m_d[k] = '0;
        end
    endtask

    task automatic check_stages();
        logic [NS*CW-1:0] ec;
        logic [NS*RW-1:0] ed;
        logic [NS-1:0]    ev;
        for (int k = 0; k < NS; k++) begin
            ec[k*CW +: CW] = m_c[k];
            ed[k*RW +: RW] = m_d[k];
            ev[k]          = m_v[k];
        end
        check("ctrl_q", 64'(ctrl_q), 64'(ec));
        check("dst_q", 64'(dst_q), 64'(ed));
        check("valid_q", 64'(valid_q), 64'(ev));
    endtask

    task automatic set_in(input logic [CW-1:0] c, input logic v, input logic [RW-1:0] d,
                          input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                          input logic urs, input logic urt,
                          input logic [NS-1:0] st, input logic [NS-1:0] fl);
        ctrl_d = c; valid_d = v; dst_d = d; rs_d = rs; rt_d = rt;
        use_rs_d = urs; use_rt_d = urt; stall_i = st; flush_i = fl;
    endtask

    // One clock: check combinational outputs, advance model, check stages after the edge.
    task automatic cycle();
        logic          lu, st;
        logic          nv [NS];
        logic [CW-1:0] nc [NS];
        logic [RW-1:0] nd [NS];
        #1;
        lu = model_loaduse();
        st = model_hold(0) || lu;
        check("loaduse", 64'(loaduse), 64'(lu));
        check("stall_d", 64'(stall_d), 64'(st));
        for (int k = 0; k < NS; k++) begin
            if (flush_i[k]) begin
                nv[k] = 1'b0; nc[k] = '0; nd[k] = '0;
            end else if (model_hold(k)) begin
                nv[k] = m_v[k]; nc[k] = m_c[k]; nd[k] = m_d[k];
            end else if (k == 0) begin
                if (lu) begin
                    nv[k] = 1'b0; nc[k] = '0; nd[k] = '0;
                end else begin
                    nv[k] = valid_d; nc[k] = ctrl_d; nd[k] = dst_d;
                end
            end else if (model_hold(k - 1)) begin
                nv[k] = 1'b0; nc[k] = '0; nd[k] = '0;
            end else begin
                nv[k] = m_v[k-1]; nc[k] = m_c[k-1]; nd[k] = m_d[k-1];
            end
        end
        @(posedge clk);
        for (int k = 0; k < NS; k++) begin
            m_v[k] = nv[k]; m_c[k] = nc[k]; m_d[k] = nd[k];
        end
        #1;
        check_stages();
    endtask

    localparam logic [CW-1:0] LW = 13'h1100;

    initial begin
        rst = 1'b1;
        set_in('0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
        model_clear();
        #12;
        check_stages();
        check("rst_loaduse", 64'(loaduse), 64'(0));
        check("rst_stall_d", 64'(stall_d), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Free flow: word visible at stage k after k+1 edges.
        set_in(13'h0A5, 1'b1, 5'd3, '0, '0, 1'b0, 1'b0, '0, '0);
        cycle();
        check("ff_s0", 64'(ctrl_q[0 +: CW]), 64'h0A5);
        set_in('0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
        cycle();
        check("ff_s1", 64'(ctrl_q[CW +: CW]), 64'h0A5);
        cycle();
        check("ff_s2", 64'(ctrl_q[2*CW +: CW]), 64'h0A5);
        check("ff_dst2", 64'(dst_q[2*RW +: RW]), 64'd3);

        // Load-use on rs.
        set_in(LW, 1'b1, 5'd5, '0, '0, 1'b0, 1'b0, '0, '0);
        cycle();
        set_in(13'h0022, 1'b1, 5'd6, 5'd5, 5'd1, 1'b1, 1'b0, '0, '0);
        #1;
        check("lu_rs", 64'(loaduse), 64'(1));
        check("lu_rs_stall", 64'(stall_d), 64'(1));
        cycle();
        check("lu_bubble", 64'(valid_q[0]), 64'(0));
        check("lu_s1", 64'(ctrl_q[CW +: CW]), 64'(LW));
        cycle();
        check("lu_enter", 64'(ctrl_q[0 +: CW]), 64'h0022);

        // Zero register never hazards.
        set_in(LW, 1'b1, 5'd0, '0, '0, 1'b0, 1'b0, '0, '0);
        cycle();
        set_in(13'h0011, 1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1, '0, '0);
        cycle();

        // Unused operand never hazards.
        set_in(LW, 1'b1, 5'd7, '0, '0, 1'b0, 1'b0, '0, '0);
        cycle();
        set_in(13'h0033, 1'b1, 5'd2, 5'd1, 5'd7, 1'b0, 1'b0, '0, '0);
        #1;
        check("unused_rt", 64'(loaduse), 64'(0));
        cycle();

        // Back-stall at stage 1 for two cycles.
        for (int i = 0; i < 3; i++) begin
            set_in(13'(16 + i), 1'b1, 5'(i + 1), '0, '0, 1'b0, 1'b0, '0, '0);
            cycle();
        end
        set_in(13'h0044, 1'b1, 5'd9, '0, '0, 1'b0, 1'b0, 3'b010, '0);
        cycle();
        check("bs_s2_bubble", 64'(valid_q[2]), 64'(0));
        cycle();
        set_in(13'h0044, 1'b1, 5'd9, '0, '0, 1'b0, 1'b0, '0, '0);
        cycle();
        set_in('0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
        cycle();
        cycle();

        // Flush beats stall in stage 0.
        set_in(13'h0055, 1'b1, 5'd4, '0, '0, 1'b0, 1'b0, '0, '0);
        cycle();
        set_in(13'h0066, 1'b1, 5'd4, '0, '0, 1'b0, 1'b0, 3'b001, 3'b001);
        cycle();
        check("flush_s0", 64'(valid_q[0]), 64'(0));

        // Asynchronous reset between edges.
        set_in(13'h0077, 1'b1, 5'd8, '0, '0, 1'b0, 1'b0, '0, '0);
        cycle();
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check("async_rst_valid", 64'(valid_q), 64'(0));
        check_stages();
        #2;
        rst = 1'b0;

        // Random traffic with a small register space to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            set_in(13'($urandom), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom),
                   ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000,
                   ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
